spi_frame_sequencer: RTL and testbench

- SPI-clock-domain frame controller between the SPI pins and the register bus bridge.
- Counts bits of each gated-clock frame, decodes read/write, and checks the write CRC.
- Issues toggle-handshake read/write requests to the clk-domain bridge and serialises read data plus CRC onto MISO.
- Frames have no chip select; framing is by bit count only, and only reset resynchronises a misaligned frame.

---
 rtl/spi_frame_sequencer_if.sv | 24 ++
 rtl/spi_frame_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_sequencer_if.sv
// Request/response bundle between the SPI frame sequencer and the clk-domain register bridge.
// The sequencer owns the request toggles; the bridge owns the read-ack toggle and read data.
interface spi_frame_sequencer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              wr_tgl_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              rd_tgl_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_ack_tgl_i;
  logic [DATA_W-1:0] rd_data_i;

  modport master (
    output wr_tgl_o, wr_addr_o, wr_data_o, rd_tgl_o, rd_addr_o,
    input  rd_ack_tgl_i, rd_data_i
  );

  modport slave (
    input  wr_tgl_o, wr_addr_o, wr_data_o, rd_tgl_o, rd_addr_o,
    output rd_ack_tgl_i, rd_data_i
  );
endinterface

// File: rtl/spi_frame_sequencer.sv
// SPI-clock-domain frame controller: counts frame bits, decodes read/write, checks write CRC,
// raises toggle requests to the bridge and serialises read data plus CRC onto MISO.
module spi_frame_sequencer #(
  parameter int          ADDR_W     = 15,
  parameter int          DATA_W     = 16,
  parameter logic [7:0]  CRC_INIT   = 8'h9C,
  parameter int          ACK_WINDOW = 6
) (
  input  logic                  spi_clk,
  input  logic                  reset,
  input  logic                  mosi_i,
  output logic                  miso_o,
  spi_frame_sequencer_if.master bus,
  output logic [7:0]            crc_err_cnt_o,
  output logic [7:0]            rd_timeout_cnt_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_WDATA = 3'd1,
    S_WCRC  = 3'd2,
    S_RWAIT = 3'd3,
    S_RDATA = 3'd4,
    S_RCRC  = 3'd5
  } state_t;

  // Pre-edge counter values of the last edge in each phase.
  localparam logic [5:0] HDR_LAST   = 6'(ADDR_W);
  localparam logic [5:0] WDATA_LAST = 6'(ADDR_W + DATA_W);
  localparam logic [5:0] WCRC_LAST  = 6'(ADDR_W + DATA_W + 8);
  localparam logic [5:0] ACK_LAST   = 6'(ADDR_W + ACK_WINDOW);
  localparam logic [5:0] RWAIT_LAST = 6'(ADDR_W + 8);
  localparam logic [5:0] RDATA_LAST = 6'(ADDR_W + 8 + DATA_W - 1);
  localparam logic [5:0] RCRC_LAST  = 6'(ADDR_W + 8 + DATA_W + 8);
  localparam logic [DATA_W-1:0] TIMEOUT_WORD = 16'hDEAD;

  function automatic logic [7:0] crc8_16(input logic [7:0] seed, input logic [15:0] d);
    logic [7:0] c;
    logic       fb;
    c = seed;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   hdr_q, hdr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          crc_sh_q, crc_sh_d;
  logic [DATA_W+7:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                busy_q, busy_d;
  logic                wr_tgl_q, wr_tgl_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                rd_tgl_q, rd_tgl_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d, seen_q, seen_d;
  logic                got_ack_q, got_ack_d;
  logic [7:0]          err_q, err_d;
  logic [7:0]          to_q, to_d;

  logic [ADDR_W-1:0]   hdr_addr_s;
  logic [7:0]          rx_crc_s;
  logic                ack_evt_s;
  logic [DATA_W-1:0]   resp_s;
  logic [7:0]          resp_crc_s;

  // State and datapath registers.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_HDR;
      cnt_q     <= 6'd0;
      hdr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      crc_sh_q  <= 8'h00;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_tgl_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_tgl_q  <= 1'b0;
      rd_addr_q <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      seen_q    <= 1'b0;
      got_ack_q <= 1'b0;
      err_q     <= 8'h00;
      to_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      crc_sh_q  <= crc_sh_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      wr_tgl_q  <= wr_tgl_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_tgl_q  <= rd_tgl_d;
      rd_addr_q <= rd_addr_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      seen_q    <= seen_d;
      got_ack_q <= got_ack_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  // Next-state and output decode; every edge of spi_clk is a frame bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 6'd1;
    hdr_d     = hdr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    crc_sh_d  = crc_sh_q;
    tx_d      = tx_q;
    miso_d    = 1'b0;
    busy_d    = 1'b1;
    wr_tgl_d  = wr_tgl_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_tgl_d  = rd_tgl_q;
    rd_addr_d = rd_addr_q;
    got_ack_d = got_ack_q;
    err_d     = err_q;
    to_d      = to_q;
    // Seen value tracks every synchronised change, so a late ack never leaks into the next read.
    sync1_d   = bus.rd_ack_tgl_i;
    sync2_d   = sync1_q;
    seen_d    = sync2_q;
    ack_evt_s = sync2_q ^ seen_q;

    hdr_addr_s = {hdr_q[ADDR_W-2:0], mosi_i};
    rx_crc_s   = {crc_sh_q[6:0], mosi_i};
    resp_s     = got_ack_q ? bus.rd_data_i : TIMEOUT_WORD;
    resp_crc_s = crc8_16(CRC_INIT, resp_s);

    case (state_q)
      S_HDR: begin
        hdr_d = hdr_addr_s;
        if (cnt_q == HDR_LAST) begin
          if (hdr_q[ADDR_W-1]) begin
            addr_d  = hdr_addr_s;
            state_d = S_WDATA;
          end else begin
            rd_addr_d = hdr_addr_s;
            rd_tgl_d  = ~rd_tgl_q;
            got_ack_d = 1'b0;
            state_d   = S_RWAIT;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_WDATA: begin
        wdata_d = {wdata_q[DATA_W-2:0], mosi_i};
        if (cnt_q == WDATA_LAST) begin
          state_d = S_WCRC;
        end else begin
          state_d = S_WDATA;
        end
      end
      S_WCRC: begin
        crc_sh_d = rx_crc_s;
        if (cnt_q == WCRC_LAST) begin
          state_d = S_HDR;
          cnt_d   = 6'd0;
          busy_d  = 1'b0;
          if (rx_crc_s == crc8_16(CRC_INIT, wdata_q)) begin
            wr_addr_d = addr_q;
            wr_data_d = wdata_q;
            wr_tgl_d  = ~wr_tgl_q;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = S_WCRC;
        end
      end
      S_RWAIT: begin
        if (ack_evt_s && (cnt_q <= ACK_LAST)) begin
          got_ack_d = 1'b1;
        end else begin
          got_ack_d = got_ack_q;
        end
        if (cnt_q == RWAIT_LAST) begin
          miso_d  = resp_s[DATA_W-1];
          tx_d    = {resp_s[DATA_W-2:0], resp_crc_s, 1'b0};
          state_d = S_RDATA;
          if (!got_ack_q && (to_q != 8'hFF)) begin
            to_d = to_q + 8'd1;
          end else begin
            to_d = to_q;
          end
        end else begin
          state_d = S_RWAIT;
        end
      end
      S_RDATA: begin
        miso_d = tx_q[DATA_W+7];
        tx_d   = {tx_q[DATA_W+6:0], 1'b0};
        if (cnt_q == RDATA_LAST) begin
          state_d = S_RCRC;
        end else begin
          state_d = S_RDATA;
        end
      end
      S_RCRC: begin
        if (cnt_q == RCRC_LAST) begin
          miso_d  = 1'b0;
          state_d = S_HDR;
          cnt_d   = 6'd0;
          busy_d  = 1'b0;
        end else begin
          miso_d = tx_q[DATA_W+7];
          tx_d   = {tx_q[DATA_W+6:0], 1'b0};
        end
      end
      default: begin
        state_d = S_HDR;
        cnt_d   = 6'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign miso_o           = miso_q;
  assign busy_o           = busy_q;
  assign crc_err_cnt_o    = err_q;
  assign rd_timeout_cnt_o = to_q;
  assign bus.wr_tgl_o     = wr_tgl_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.rd_tgl_o     = rd_tgl_q;
  assign bus.rd_addr_o    = rd_addr_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer: table of frames plus hand sequences for
// CRC-error saturation, mid-frame reset and gapped random traffic.
module tb_spi_frame_sequencer;
  logic       spi_clk;
  logic       reset;
  logic       mosi_i;
  logic       miso_o;
  logic [7:0] crc_err_cnt_o;
  logic [7:0] rd_timeout_cnt_o;
  logic       busy_o;

  spi_frame_sequencer_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  spi_frame_sequencer #(
    .ADDR_W(15), .DATA_W(16), .CRC_INIT(8'h9C), .ACK_WINDOW(6)
  ) dut (
    .spi_clk          (spi_clk),
    .reset            (reset),
    .mosi_i           (mosi_i),
    .miso_o           (miso_o),
    .bus              (bus),
    .crc_err_cnt_o    (crc_err_cnt_o),
    .rd_timeout_cnt_o (rd_timeout_cnt_o),
    .busy_o           (busy_o)
  );

  typedef struct {
    logic        rw;
    logic [14:0] addr;
    logic [15:0] data;
    logic        bad_crc;
    int          ack_after;
    logic [15:0] exp_resp;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_bad = 0;

  logic        m_wr_tgl, m_rd_tgl;
  logic [14:0] m_wr_addr, m_rd_addr;
  logic [15:0] m_wr_data;
  logic [7:0]  m_err, m_to;

  // CRC-8/0x07 as polynomial long division of seed*x^16 + data*x^8.
  function automatic logic [7:0] crc_model(input logic [15:0] d);
    logic [23:0] v;
    v = {d, 8'h00} ^ {8'h9C, 16'h0000};
    for (int i = 23; i >= 8; i--) begin
      if (v[i]) v = v ^ ({15'd0, 9'h107} << (i - 8));
    end
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wr_tgl"},  32'(bus.wr_tgl_o),    32'(m_wr_tgl));
    check({tag, ".wr_addr"}, 32'(bus.wr_addr_o),   32'(m_wr_addr));
    check({tag, ".wr_data"}, 32'(bus.wr_data_o),   32'(m_wr_data));
    check({tag, ".rd_tgl"},  32'(bus.rd_tgl_o),    32'(m_rd_tgl));
    check({tag, ".rd_addr"}, 32'(bus.rd_addr_o),   32'(m_rd_addr));
    check({tag, ".crc_err"}, 32'(crc_err_cnt_o),   32'(m_err));
    check({tag, ".rd_to"},   32'(rd_timeout_cnt_o), 32'(m_to));
    check({tag, ".busy_end"}, 32'(busy_o),         32'd0);
  endtask

  // Bits are left-justified: frame bit n sits at fbits[47-n]; miso after edge e lands at mbits[48-e].
  task automatic run_frame(input logic [47:0] fbits, input int nbits, input int ack_after,
                           input logic [15:0] ack_data, input int gap,
                           output logic [47:0] mbits, output logic busy_first);
    mbits      = 48'd0;
    busy_first = 1'b0;
    for (int e = 1; e <= nbits; e++) begin
      mosi_i = fbits[48-e];
      #5 spi_clk = 1'b1;
      #5 spi_clk = 1'b0;
      mbits[48-e] = miso_o;
      if (e == 1) busy_first = busy_o;
      if (e == ack_after) begin
        bus.rd_data_i    = ack_data;
        bus.rd_ack_tgl_i = ~bus.rd_ack_tgl_i;
      end
      if ((gap > 0) && (e % 8 == 0)) #(gap * 10);
    end
    mosi_i = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic rw, input logic [14:0] addr,
                          input logic [15:0] data, input logic bad, input int ack_after,
                          input logic [15:0] exp_resp, input logic exp_to, input int gap);
    logic [47:0] fbits, mbits;
    logic        bf;
    logic [7:0]  crc;
    if (rw) begin
      crc   = crc_model(data) ^ (bad ? 8'h01 : 8'h00);
      fbits = {1'b1, addr, data, crc, 8'h00};
      run_frame(fbits, 40, 0, 16'h0000, gap, mbits, bf);
      if (!bad) begin
        m_wr_tgl  = ~m_wr_tgl;
        m_wr_addr = addr;
        m_wr_data = data;
      end else if (m_err != 8'hFF) begin
        m_err = m_err + 8'd1;
      end
      check({tag, ".miso_idle"}, mbits[31:0], 32'd0);
    end else begin
      fbits = {1'b0, addr, 32'h0000_0000};
      run_frame(fbits, 48, ack_after, data, gap, mbits, bf);
      m_rd_tgl  = ~m_rd_tgl;
      m_rd_addr = addr;
      if (exp_to && (m_to != 8'hFF)) m_to = m_to + 8'd1;
      check({tag, ".resp"},      32'(mbits[24:9]), 32'(exp_resp));
      check({tag, ".resp_crc"},  32'(mbits[8:1]),  32'(crc_model(exp_resp)));
      check({tag, ".miso_tail"}, 32'(mbits[0]),    32'd0);
      check({tag, ".miso_head"}, 32'(mbits[47:25]), 32'd0);
    end
    check({tag, ".busy_first"}, 32'(bf), 32'd1);
    check_model(tag);
  endtask

  task automatic model_reset();
    m_wr_tgl = 1'b0; m_rd_tgl = 1'b0;
    m_wr_addr = 15'd0; m_rd_addr = 15'd0; m_wr_data = 16'd0;
    m_err = 8'd0; m_to = 8'd0;
  endtask

  initial begin
    logic [47:0] mb;
    logic        bf;
    logic [14:0] ra;
    logic [15:0] rd;

    vecs[0] = '{rw:1'b1, addr:15'h0004, data:16'hA5C3, bad_crc:1'b0, ack_after:0,  exp_resp:16'h0000, exp_to:1'b0};
    vecs[1] = '{rw:1'b1, addr:15'h0004, data:16'hA5C3, bad_crc:1'b1, ack_after:0,  exp_resp:16'h0000, exp_to:1'b0};
    vecs[2] = '{rw:1'b0, addr:15'h0004, data:16'h1234, bad_crc:1'b0, ack_after:16, exp_resp:16'h1234, exp_to:1'b0};
    vecs[3] = '{rw:1'b0, addr:15'h0004, data:16'h0000, bad_crc:1'b0, ack_after:0,  exp_resp:16'hDEAD, exp_to:1'b1};
    vecs[4] = '{rw:1'b0, addr:15'h0007, data:16'h00FF, bad_crc:1'b0, ack_after:17, exp_resp:16'h00FF, exp_to:1'b0};
    vecs[5] = '{rw:1'b0, addr:15'h7FFF, data:16'hBEEF, bad_crc:1'b0, ack_after:19, exp_resp:16'hBEEF, exp_to:1'b0};
    vecs[6] = '{rw:1'b0, addr:15'h1111, data:16'hCAFE, bad_crc:1'b0, ack_after:20, exp_resp:16'hDEAD, exp_to:1'b1};
    vecs[7] = '{rw:1'b0, addr:15'h2222, data:16'h5A5A, bad_crc:1'b0, ack_after:16, exp_resp:16'h5A5A, exp_to:1'b0};

    spi_clk = 1'b0; mosi_i = 1'b0; reset = 1'b1;
    bus.rd_ack_tgl_i = 1'b0; bus.rd_data_i = 16'h0000;
    model_reset();
    #20;
    check_model("reset");
    check("reset.miso", 32'(miso_o), 32'd0);
    reset = 1'b0;
    #10;

    for (int i = 0; i < 8; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].bad_crc,
               vecs[i].ack_after, vecs[i].exp_resp, vecs[i].exp_to, 0);
    end

    for (int i = 0; i < 256; i++) begin
      do_frame("sat", 1'b1, 15'h0004, 16'hA5C3, 1'b1, 0, 16'h0000, 1'b0, 0);
    end
    check("sat.final", 32'(crc_err_cnt_o), 32'd255);

    run_frame({1'b1, 15'h0004, 16'hA5C3, crc_model(16'hA5C3), 8'h00}, 20, 0, 16'h0000, 0, mb, bf);
    reset = 1'b1;
    bus.rd_ack_tgl_i = 1'b0;
    #5;
    model_reset();
    check_model("midrst");
    check("midrst.miso", 32'(miso_o), 32'd0);
    reset = 1'b0;
    #10;
    do_frame("post_rst", 1'b1, 15'h0002, 16'h0001, 1'b0, 0, 16'h0000, 1'b0, 0);
    check("post_rst.one_toggle", 32'(bus.wr_tgl_o), 32'd1);

    for (int i = 0; i < 10; i++) begin
      ra = 15'($urandom_range(0, 32767));
      rd = 16'($urandom);
      if (i % 2 == 0) begin
        do_frame($sformatf("rnd%0d", i), 1'b1, ra, rd, 1'b0, 0, 16'h0000, 1'b0, 3);
      end else begin
        do_frame($sformatf("rnd%0d", i), 1'b0, ra, rd, 1'b0, 16 + int'($urandom_range(0, 3)),
                 rd, 1'b0, 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
